// File: rtl/aes_dec_seq_pkg.sv
// Shared types and constants for the AES-256 decipher sequencer.
// Widths, default tuning values and the control FSM encoding.
package aes_dec_seq_pkg;

  localparam int TEXT_W           = 128;
  localparam int KEY_W            = 256;
  localparam int ISSUE_GAP_DEF    = 8;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYWAIT = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/aes_dec_seq_fifo.sv
// Result buffer: synchronous FIFO holding {last, plaintext} entries.
// Count output feeds the issue credit check in the sequencer.
module aes_dec_seq_fifo
  import aes_dec_seq_pkg::*;
#(
  parameter int WIDTH = TEXT_W + 1,
  parameter int DEPTH = MAX_INFLIGHT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/aes_dec_sequencer.sv
// Feeds ciphertext blocks to a pipelined AES-256 decipher core with
// issue spacing and output credit, and returns plaintext in order.
module aes_dec_sequencer
  import aes_dec_seq_pkg::*;
#(
  parameter int ISSUE_GAP    = ISSUE_GAP_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_load,
  input  logic [TEXT_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [TEXT_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [TEXT_W-1:0] core_text,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_key_valid,
  output logic              core_start,
  output logic              core_last,
  input  logic [TEXT_W-1:0] core_result,
  input  logic              core_ready_text,
  input  logic              core_pipe_ready,
  input  logic              core_done,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int SW = CW + 1;
  localparam int GW = $clog2(ISSUE_GAP) + 1;

  state_e            state_q;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [CW-1:0]     fifo_cnt;
  logic [TEXT_W-1:0] text_q;
  logic [KEY_W-1:0]  key_q;
  logic              kv_q, start_q, last_q, err_q;
  logic              fire, rx_ok, rx_bad, pop, credit;
  logic              fifo_full, fifo_empty, tag_last;
  logic [TEXT_W:0]   fifo_rd;

  assign credit = ({1'b0, infl_q} + {1'b0, fifo_cnt}) < SW'(MAX_INFLIGHT);
  assign s_ready = (state_q == RUN) && core_pipe_ready &&
                   (gap_q == '0) && credit && !key_load;
  assign fire   = s_valid && s_ready;
  assign rx_ok  = core_ready_text && (infl_q != '0) && !fifo_full;
  assign rx_bad = core_ready_text && !rx_ok;
  assign pop    = m_valid && m_ready;
  // Results return in order, so the final one of a drain is the last block.
  assign tag_last = last_q && (infl_q == CW'(1));

  assign infl_d = infl_q + CW'(fire) - CW'(rx_ok);
  assign gap_d  = fire ? GW'(ISSUE_GAP - 1) :
                  (gap_q != '0) ? gap_q - 1'b1 : gap_q;

  aes_dec_seq_fifo #(
    .WIDTH (TEXT_W + 1),
    .DEPTH (MAX_INFLIGHT)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_ok),
    .pop_i   (pop),
    .wdata_i ({tag_last, core_result}),
    .rdata_o (fifo_rd),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_valid        = !fifo_empty;
  assign m_last         = fifo_rd[TEXT_W];
  assign m_data         = fifo_rd[TEXT_W-1:0];
  assign core_text      = text_q;
  assign core_key       = key_q;
  assign core_key_valid = kv_q;
  assign core_start     = start_q;
  assign core_last      = last_q;
  assign err            = err_q;
  assign busy = (state_q == KEYWAIT) || (state_q == DRAIN) ||
                (infl_q != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      infl_q  <= '0;
      text_q  <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      infl_q  <= infl_d;
      gap_q   <= gap_d;
      start_q <= fire;
      if (fire) text_q <= s_data;
      if (rx_bad || (core_done && state_q == DRAIN)) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (key_load) begin
            state_q <= KEYWAIT;
            key_q   <= key_in;
            kv_q    <= 1'b1;
          end
        end
        KEYWAIT: begin
          if (key_load)             err_q   <= 1'b1;
          else if (core_pipe_ready) state_q <= RUN;
        end
        RUN: begin
          if (key_load) begin
            if (infl_q == '0) begin
              state_q <= KEYWAIT;
              key_q   <= key_in;
            end else begin
              err_q <= 1'b1;
            end
          end else if (fire && s_last) begin
            state_q <= DRAIN;
            last_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (key_load) err_q <= 1'b1;
          if (infl_q == '0 && fifo_empty) begin
            state_q <= RUN;
            last_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Scoreboard bench for aes_dec_sequencer with a behavioural core model.
// Expected plaintext is queued at issue and compared at the output.
module tb_aes_dec_sequencer;

  localparam logic [255:0] NK =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key_in = '0;
  logic         key_load = 1'b0;
  logic [127:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [127:0] m_data;
  logic         m_valid, m_last;
  logic         m_ready = 1'b0;
  logic [127:0] core_text;
  logic [255:0] core_key;
  logic         core_key_valid, core_start, core_last;
  logic [127:0] core_result = '0;
  logic         core_ready_text = 1'b0;
  logic         core_pipe_ready = 1'b0;
  logic         core_done = 1'b0;
  logic         busy, err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_start = -1;
  int lat_min = 3;
  int spur_req = 0;
  int spur_done = 0;
  logic [255:0] key_cur = '0;
  logic [128:0] exp_q[$];
  logic [127:0] src_q[$];

  typedef struct {
    int           due;
    logic [127:0] res;
  } core_ent_t;
  core_ent_t core_q[$];

  aes_dec_sequencer u_dut (
    .clock           (clock),
    .reset           (rst_n),
    .key_in          (key_in),
    .key_load        (key_load),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_last          (m_last),
    .m_ready         (m_ready),
    .core_text       (core_text),
    .core_key        (core_key),
    .core_key_valid  (core_key_valid),
    .core_start      (core_start),
    .core_last       (core_last),
    .core_result     (core_result),
    .core_ready_text (core_ready_text),
    .core_pipe_ready (core_pipe_ready),
    .core_done       (core_done),
    .busy            (busy),
    .err             (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Stand-in for the decipher core: NIST vectors for the NIST key,
  // otherwise a key-dependent mix so a wrong key shows as wrong data.
  function automatic logic [127:0] dec(input logic [127:0] c,
                                       input logic [255:0] k);
    logic [127:0] ct [4];
    logic [127:0] pt [4];
    ct = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
           128'h591ccb10d410ed26dc5ba74a31362870,
           128'hb6ed21b99ca6f4f9f153e7b1beafed1d,
           128'h23304b7a39f9f3ff067d8d8f9e24ecc7};
    pt = '{128'h6bc1bee22e409f96e93d7e117393172a,
           128'hae2d8a571e03ac9c9eb76fac45af8e51,
           128'h30c81c46a35ce411e5fbc1191a0a52ef,
           128'hf69f2445df4f9b17ad2b417be66c3710};
    dec = c ^ k[255:128] ^ {k[63:0], k[127:64]};
    if (k == NK)
      for (int i = 0; i < 4; i++)
        if (c == ct[i]) dec = pt[i];
  endfunction

  function automatic logic [127:0] next_blk();
    if (src_q.size() != 0) return src_q.pop_front();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model: variable in-order latency; not cleared by reset.
  always @(negedge clock) begin
    int d;
    cyc++;
    core_ready_text = 1'b0;
    if (!rst_n) last_start = -1;
    if (core_start) begin
      if (last_start >= 0) chk("start_gap", (cyc - last_start) >= 8, 1);
      last_start = cyc;
      d = cyc + $urandom_range(lat_min, lat_min + 17);
      if (core_q.size() != 0 && d <= core_q[$].due) d = core_q[$].due + 1;
      core_q.push_back('{due: d, res: dec(core_text, core_key)});
    end
    if (spur_req != spur_done) begin
      spur_done = spur_req;
      core_ready_text = 1'b1;
      core_result = {$urandom, $urandom, $urandom, $urandom};
    end else if (core_q.size() != 0 && core_q[0].due <= cyc) begin
      core_ready_text = 1'b1;
      core_result = core_q[0].res;
      void'(core_q.pop_front());
    end
  end

  always @(negedge clock) begin
    logic [128:0] e;
    #2;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {m_last, m_data}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", m_data, e[127:0]);
        chk("out_last", m_last, e[128]);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    key_load = 1'b0; key_in = '0; m_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_core_text", core_text, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_key_valid", core_key_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_last", core_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
  endtask

  task automatic load_key(input logic [255:0] k);
    @(negedge clock);
    key_in = k; key_load = 1'b1;
    @(negedge clock);
    key_load = 1'b0;
    key_cur = k;
    #1;
    chk("key_latched", core_key, k);
    chk("key_valid", core_key_valid, 1);
  endtask

  task automatic stream(input int n, input bit with_last, input int hold,
                        input bit rnd, output int acc_hold);
    int i, c;
    logic [127:0] blk;
    i = 0; c = 0; acc_hold = 0;
    blk = next_blk();
    while (i < n && c < 3000) begin
      @(negedge clock);
      c++;
      m_ready = (c <= hold) ? 1'b0 :
                (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rnd) core_pipe_ready = ($urandom_range(0, 3) != 0);
      s_valid = 1'b1; s_data = blk;
      s_last = with_last && (i == n - 1);
      #1;
      if (s_ready) begin
        exp_q.push_back({s_last, dec(blk, key_cur)});
        i++;
        if (i < n) blk = next_blk();
      end
      if (c == hold) acc_hold = i;
    end
    @(negedge clock);
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    core_pipe_ready = 1'b1;
    chk("stream_accepted", i, n);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    m_ready = 1'b1;
    do begin
      @(negedge clock);
      t++;
    end while ((exp_q.size() != 0 || busy) && t < 600);
    chk("drain_idle", (exp_q.size() == 0) && !busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit seen;
    logic [255:0] k2;

    do_reset();

    // Key load, then RUN one cycle after core_pipe_ready rises.
    core_pipe_ready = 1'b0;
    load_key(NK);
    chk("keywait_busy", busy, 1);
    chk("keywait_sready", s_ready, 0);
    repeat (2) @(negedge clock);
    core_pipe_ready = 1'b1;
    #1 chk("keywait_hold", s_ready, 0);
    @(negedge clock);
    #1 chk("run_sready", s_ready, 1);
    chk("run_not_busy", busy, 0);

    // NIST ECB-AES256 decrypt vectors.
    src_q.push_back(128'hf3eed1bdb5d2a03c064b5a7e3db181f8);
    src_q.push_back(128'h591ccb10d410ed26dc5ba74a31362870);
    src_q.push_back(128'hb6ed21b99ca6f4f9f153e7b1beafed1d);
    src_q.push_back(128'h23304b7a39f9f3ff067d8d8f9e24ecc7);
    stream(4, 1, 0, 0, acc);
    wait_idle();
    chk("nist_err", err, 0);

    // Output stalled: credit admits only MAX_INFLIGHT blocks.
    stream(6, 1, 150, 0, acc);
    chk("credit_accept", acc, 4);
    wait_idle();
    chk("credit_err", err, 0);

    // Push and pop in the same cycle with two entries buffered.
    stream(2, 0, 1_000_000, 0, acc);
    repeat (60) @(negedge clock);
    chk("fifo_two", u_dut.u_fifo.count_o, 2);
    stream(1, 1, 1_000_000, 0, acc);
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clock);
      #1;
      if (core_ready_text) begin
        m_ready = 1'b1;
        seen = 1'b1;
      end
    end
    @(negedge clock);
    m_ready = 1'b0;
    chk("pushpop_seen", seen, 1);
    chk("pushpop_count", u_dut.u_fifo.count_o, 2);
    chk("pushpop_err", err, 0);
    wait_idle();

    // key_load during DRAIN is ignored and flagged.
    k2 = rkey();
    stream(1, 1, 0, 0, acc);
    @(negedge clock);
    key_in = k2; key_load = 1'b1;
    @(negedge clock);
    key_load = 1'b0;
    #1;
    chk("drain_key_err", err, 1);
    chk("drain_key_kept", core_key, key_cur);
    wait_idle();
    load_key(k2);
    chk("rekey_busy", busy, 1);
    stream(1, 1, 0, 0, acc);
    wait_idle();

    // Reset with blocks in flight: late results are errors.
    lat_min = 30;
    stream(3, 1, 0, 0, acc);
    do_reset();
    repeat (80) @(negedge clock);
    chk("late_result_err", err, 1);
    chk("late_result_mvalid", m_valid, 0);
    lat_min = 3;

    // Spurious result in IDLE.
    do_reset();
    spur_req++;
    repeat (4) @(negedge clock);
    chk("spur_err", err, 1);
    chk("spur_mvalid", m_valid, 0);
    do_reset();

    // Random traffic with output and pipe-ready stalls.
    load_key(rkey());
    stream(12, 1, 0, 1, acc);
    wait_idle();
    chk("rand1_err", err, 0);
    stream(8, 1, 0, 1, acc);
    wait_idle();
    chk("rand2_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
